// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
// One transaction in flight; response returns as a single-cycle valid pulse.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      INSTR_BUSY = 2'd1,
      DATA_BUSY  = 2'd2,
      RESP       = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_INSTR = 1'b0,
      OWN_DATA  = 1'b1
   } arb_owner_t;

   // Read data returned to the owner when a transaction is aborted.
   localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter_timer.sv
// Loadable down-counter: clear reloads, run counts down, expired flags the last running cycle.
// Zero latency on expired; no backpressure.
module mem_arbiter_timer #(
   parameter int unsigned CYCLES = 255
) (
   input  logic CLK,
   input  logic RES,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [CW-1:0] count;

   // Loading CYCLES-1 makes expired assert in the CYCLES-th running cycle.
   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         count <= '0;
      end else if (clear) begin
         count <= CW'(CYCLES - 1);
      end else if (run && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign expired = run && (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority (data over fetch) arbiter for one external memory port; 3 cycles min per transaction.
// Requests are levels held until *_valid; optional abort on missing ack with MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned AW             = 32,
   parameter int unsigned DW             = 32
) (
   input  logic          CLK,
   input  logic          RES,
   input  logic          instr_req,
   input  logic [AW-1:0] instr_adr,
   output logic [DW-1:0] instr_read,
   output logic          instr_valid,
   input  logic          data_req,
   input  logic          data_write_enable,
   input  logic [AW-1:0] data_adr,
   input  logic [DW-1:0] data_write,
   output logic [DW-1:0] data_read,
   output logic          data_valid,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          bus_err
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
      $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   arb_state_t    state;
   arb_owner_t    owner;
   logic          busy;
   logic          grant;
   logic          timeout;
   logic          finish;
   logic [DW-1:0] resp_dat;

   assign busy  = (state == INSTR_BUSY) || (state == DATA_BUSY);
   assign grant = (state == IDLE) && (data_req || instr_req);

`ifdef MEM_ARBITER_TIMEOUT_EN
   logic expired;

   mem_arbiter_timer #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .CLK     (CLK),
      .RES     (RES),
      .clear   (grant),
      .run     (busy),
      .expired (expired)
   );

   // An ack in the expiry cycle is a normal completion.
   assign timeout = expired && !mem_ack;

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         bus_err <= 1'b0;
      end else if (busy && timeout) begin
         bus_err <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign bus_err = 1'b0;
`endif

   assign finish   = busy && (mem_ack || timeout);
   assign resp_dat = mem_ack ? mem_rdata : DW'(ARB_ERR_DATA);

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         state       <= IDLE;
         owner       <= OWN_INSTR;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_adr     <= '0;
         mem_wdata   <= '0;
         instr_read  <= '0;
         data_read   <= '0;
         instr_valid <= 1'b0;
         data_valid  <= 1'b0;
      end else begin
         instr_valid <= 1'b0;
         data_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (data_req) begin
                  state     <= DATA_BUSY;
                  owner     <= OWN_DATA;
                  mem_req   <= 1'b1;
                  mem_we    <= data_write_enable;
                  mem_adr   <= data_adr;
                  mem_wdata <= data_write;
               end else if (instr_req) begin
                  state     <= INSTR_BUSY;
                  owner     <= OWN_INSTR;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_adr   <= instr_adr;
                  mem_wdata <= '0;
               end
            end
            INSTR_BUSY, DATA_BUSY: begin
               if (finish) begin
                  state   <= RESP;
                  mem_req <= 1'b0;
                  if (owner == OWN_DATA) begin
                     data_read  <= resp_dat;
                     data_valid <= 1'b1;
                  end else begin
                     instr_read  <= resp_dat;
                     instr_valid <= 1'b1;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; memory acks are driven by hand per vector.
// Define MEM_ARBITER_TIMEOUT_EN for both files to exercise the abort path.
module tb_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          CLK;
   logic          RES;
   logic          instr_req;
   logic [AW-1:0] instr_adr;
   logic [DW-1:0] instr_read;
   logic          instr_valid;
   logic          data_req;
   logic          data_write_enable;
   logic [AW-1:0] data_adr;
   logic [DW-1:0] data_write;
   logic [DW-1:0] data_read;
   logic          data_valid;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   logic          bus_err;

   int n_checks = 0;
   int n_errors = 0;

   // Values captured by run_txn
   int          lat;
   logic        cap_req;
   logic        cap_we;
   logic [31:0] cap_adr;
   logic [31:0] cap_wdata;
   logic [31:0] cap_adr_ack;
   logic        got_iv;
   logic        got_dv;

   mem_arbiter #(
      .TIMEOUT_CYCLES (8),
      .AW             (AW),
      .DW             (DW)
   ) dut (
      .CLK               (CLK),
      .RES               (RES),
      .instr_req         (instr_req),
      .instr_adr         (instr_adr),
      .instr_read        (instr_read),
      .instr_valid       (instr_valid),
      .data_req          (data_req),
      .data_write_enable (data_write_enable),
      .data_adr          (data_adr),
      .data_write        (data_write),
      .data_read         (data_read),
      .data_valid        (data_valid),
      .mem_req           (mem_req),
      .mem_we            (mem_we),
      .mem_adr           (mem_adr),
      .mem_wdata         (mem_wdata),
      .mem_rdata         (mem_rdata),
      .mem_ack           (mem_ack),
      .bus_err           (bus_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Steps until a valid pulse (bounded). ack_at = cycle index in which mem_ack is driven
   // (1 = first cycle after the grant edge); 0 means never ack.
   task automatic run_txn(input int ack_at, input logic [31:0] rd, input bit chg_adr);
      lat    = 0;
      got_iv = 1'b0;
      got_dv = 1'b0;
      while (lat < 40) begin
         step();
         lat++;
         mem_ack = 1'b0;
         if (lat == 1) begin
            cap_req   = mem_req;
            cap_we    = mem_we;
            cap_adr   = mem_adr;
            cap_wdata = mem_wdata;
            if (chg_adr) data_adr = 32'h0BAD_0000;
         end
         if (instr_valid || data_valid) begin
            got_iv = instr_valid;
            got_dv = data_valid;
            break;
         end
         if (lat == ack_at) begin
            cap_adr_ack = mem_adr;
            mem_ack     = 1'b1;
            mem_rdata   = rd;
         end
      end
   endtask

   initial begin
      int   seen;
      logic stuck;

      RES               = 1'b0;
      instr_req         = 1'b0;
      instr_adr         = '0;
      data_req          = 1'b0;
      data_write_enable = 1'b0;
      data_adr          = '0;
      data_write        = '0;
      mem_rdata         = '0;
      mem_ack           = 1'b0;
      cap_adr_ack       = '0;

      // Reset state
      step();
      step();
      chk("rst_mem_req",     32'(mem_req),     32'd0);
      chk("rst_mem_we",      32'(mem_we),      32'd0);
      chk("rst_mem_adr",     mem_adr,          32'd0);
      chk("rst_mem_wdata",   mem_wdata,        32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_data_valid",  32'(data_valid),  32'd0);
      chk("rst_instr_read",  instr_read,       32'd0);
      chk("rst_data_read",   data_read,        32'd0);
      chk("rst_bus_err",     32'(bus_err),     32'd0);
      RES = 1'b1;
      step();

      // Single fetch, ack two cycles late: 4 cycles from req to valid
      instr_req = 1'b1;
      instr_adr = 32'h0000_0010;
      run_txn(3, 32'h0010_0093, 1'b0);
      chk("fetch_mem_req",  32'(cap_req), 32'd1);
      chk("fetch_mem_adr",  cap_adr,      32'h0000_0010);
      chk("fetch_mem_we",   32'(cap_we),  32'd0);
      chk("fetch_iv",       32'(got_iv),  32'd1);
      chk("fetch_dv",       32'(got_dv),  32'd0);
      chk("fetch_read",     instr_read,   32'h0010_0093);
      chk("fetch_latency",  32'(lat),     32'd4);
      step();
      instr_req = 1'b0;
      chk("fetch_pulse_len", 32'(instr_valid), 32'd0);
      chk("fetch_req_drop",  32'(mem_req),     32'd0);
      step();

      // Simultaneous requests: data first, fetch after RESP + IDLE
      instr_req         = 1'b1;
      instr_adr         = 32'h0000_0020;
      data_req          = 1'b1;
      data_write_enable = 1'b0;
      data_adr          = 32'h0000_0100;
      run_txn(1, 32'h1111_2222, 1'b0);
      chk("simul_first_dv",  32'(got_dv), 32'd1);
      chk("simul_first_iv",  32'(got_iv), 32'd0);
      chk("simul_first_adr", cap_adr,     32'h0000_0100);
      chk("simul_data_read", data_read,   32'h1111_2222);
      chk("simul_first_lat", 32'(lat),    32'd2);
      step();
      data_req = 1'b0;
      chk("simul_gap_req",  32'(mem_req),    32'd0);
      chk("simul_gap_dv",   32'(data_valid), 32'd0);
      run_txn(1, 32'h3333_4444, 1'b0);
      chk("simul_second_req", 32'(cap_req), 32'd1);
      chk("simul_second_adr", cap_adr,      32'h0000_0020);
      chk("simul_second_iv",  32'(got_iv),  32'd1);
      chk("simul_instr_read", instr_read,   32'h3333_4444);
      chk("simul_data_hold",  data_read,    32'h1111_2222);
      chk("simul_second_lat", 32'(lat),     32'd2);
      step();
      instr_req = 1'b0;
      step();

      // Zero-wait store
      data_req          = 1'b1;
      data_write_enable = 1'b1;
      data_adr          = 32'h0000_0200;
      data_write        = 32'hCAFE_F00D;
      run_txn(1, 32'h5555_6666, 1'b0);
      chk("store_mem_we",    32'(cap_we), 32'd1);
      chk("store_mem_adr",   cap_adr,     32'h0000_0200);
      chk("store_mem_wdata", cap_wdata,   32'hCAFE_F00D);
      chk("store_dv",        32'(got_dv), 32'd1);
      chk("store_latency",   32'(lat),    32'd2);
      chk("store_instr_hold", instr_read, 32'h3333_4444);
      step();
      data_req          = 1'b0;
      data_write_enable = 1'b0;
      step();

      // Address change while busy must not reach the memory side
      data_req = 1'b1;
      data_adr = 32'h0000_0300;
      run_txn(3, 32'h7777_8888, 1'b1);
      chk("chg_adr_ack",  cap_adr_ack, 32'h0000_0300);
      chk("chg_dv",       32'(got_dv), 32'd1);
      chk("chg_read",     data_read,   32'h7777_8888);
      step();
      data_req = 1'b0;
      step();

      // Stray ack in IDLE is ignored
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_0000;
      step();
      mem_ack = 1'b0;
      step();
      chk("stray_mem_req",  32'(mem_req),                  32'd0);
      chk("stray_valid",    32'(instr_valid | data_valid), 32'd0);
      chk("stray_instr_rd", instr_read,                    32'h3333_4444);

      // Asynchronous reset during INSTR_BUSY
      instr_req = 1'b1;
      instr_adr = 32'h0000_0040;
      step();
      chk("arst_pre_req", 32'(mem_req), 32'd1);
      #2;
      RES = 1'b0;
      #1;
      chk("arst_mem_req",    32'(mem_req),  32'd0);
      chk("arst_mem_adr",    mem_adr,       32'd0);
      chk("arst_instr_read", instr_read,    32'd0);
      chk("arst_data_read",  data_read,     32'd0);
      instr_req = 1'b0;
      step();
      mem_ack   = 1'b1;
      mem_rdata = 32'h1234_5678;
      #3;
      RES = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         mem_ack = 1'b0;
         if (instr_valid || mem_req) seen++;
      end
      chk("arst_no_resp", 32'(seen), 32'd0);

`ifdef MEM_ARBITER_TIMEOUT_EN
      // Ack in the expiry cycle completes normally
      instr_req = 1'b1;
      instr_adr = 32'h0000_0050;
      run_txn(8, 32'hAAAA_5555, 1'b0);
      chk("to_race_iv",   32'(got_iv),  32'd1);
      chk("to_race_read", instr_read,   32'hAAAA_5555);
      chk("to_race_err",  32'(bus_err), 32'd0);
      step();
      instr_req = 1'b0;
      step();

      // No ack: abort after 8 busy cycles
      instr_req = 1'b1;
      run_txn(0, 32'h0, 1'b0);
      chk("to_iv",      32'(got_iv),  32'd1);
      chk("to_latency", 32'(lat),     32'd9);
      chk("to_read",    instr_read,   32'hDEAD_BEEF);
      chk("to_mem_req", 32'(mem_req), 32'd0);
      chk("to_err",     32'(bus_err), 32'd1);
      step();
      instr_req = 1'b0;
      run_txn(0, 32'h0, 1'b0);
      data_req = 1'b1;
      run_txn(1, 32'h0F0F_0F0F, 1'b0);
      chk("to_err_sticky", 32'(bus_err), 32'd1);
      chk("to_after_read", data_read,    32'h0F0F_0F0F);
      step();
      data_req = 1'b0;
      step();
`else
      // Without the abort feature the transaction waits for ack indefinitely
      instr_req = 1'b1;
      instr_adr = 32'h0000_0050;
      seen  = 0;
      stuck = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (instr_valid) seen++;
         if (!mem_req) stuck = 1'b0;
      end
      chk("noto_req_held", 32'(stuck),   32'd1);
      chk("noto_no_valid", 32'(seen),    32'd0);
      chk("noto_bus_err",  32'(bus_err), 32'd0);
      run_txn(1, 32'h2468_ACE0, 1'b0);
      chk("noto_late_iv",   32'(got_iv), 32'd1);
      chk("noto_late_read", instr_read,  32'h2468_ACE0);
      step();
      instr_req = 1'b0;
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
